// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution: BHT of 2-bit counters plus a tagged BTB on the
// fetch side, branch/jump resolution and table training on the execute side.
// Optional performance counters are built only when BP_PERF_CNT_EN is defined.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             if_valid_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             ex_valid_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_rs1_data_i,
    input  logic [XLEN-1:0]  ex_rs2_data_i,
    input  logic [XLEN-1:0]  ex_imm_i,
    input  logic [2:0]       ex_branch_type_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  ex_pred_target_i,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             resolved_taken_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = XLEN - BTB_IW - 2;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [1:0]       bht_r        [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_r;
    logic [TAG_W-1:0] btb_tag_r    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target_r [BTB_ENTRIES];
    logic             btb_jump_r   [BTB_ENTRIES];

    logic             redirect_valid_r;
    logic [XLEN-1:0]  redirect_pc_r;
    logic             resolved_taken_r;

    logic [BHT_IW-1:0] if_bht_idx_s, ex_bht_idx_s;
    logic [BTB_IW-1:0] if_btb_idx_s, ex_btb_idx_s;
    logic [TAG_W-1:0]  if_tag_s, ex_tag_s;
    logic              btb_hit_s, pred_taken_s;
    logic [XLEN-1:0]   pred_target_s;
    logic              cond_taken_s, is_jump_s, act_taken_s, mispredict_s, accept_s;
    logic [XLEN-1:0]   act_target_s, act_next_pc_s;
    logic [1:0]        bht_next_s;

    assign if_bht_idx_s = if_pc_i[BHT_IW+1:2];
    assign if_btb_idx_s = if_pc_i[BTB_IW+1:2];
    assign if_tag_s     = if_pc_i[XLEN-1:BTB_IW+2];
    assign ex_bht_idx_s = ex_pc_i[BHT_IW+1:2];
    assign ex_btb_idx_s = ex_pc_i[BTB_IW+1:2];
    assign ex_tag_s     = ex_pc_i[XLEN-1:BTB_IW+2];

    // Fetch-side lookup; reads the tables as they stand before this cycle's update.
    always_comb begin
        btb_hit_s    = btb_valid_r[if_btb_idx_s] && (btb_tag_r[if_btb_idx_s] == if_tag_s);
        pred_taken_s = if_valid_i && btb_hit_s &&
                       (btb_jump_r[if_btb_idx_s] || bht_r[if_bht_idx_s][1]);
        if (pred_taken_s) begin
            pred_target_s = btb_target_r[if_btb_idx_s];
        end else begin
            pred_target_s = if_pc_i + PC_STEP;
        end
    end

    // Conditional branch comparison on funct3 encoding.
    always_comb begin
        cond_taken_s = 1'b0;
        case (ex_branch_type_i)
            BR_BEQ:  cond_taken_s = (ex_rs1_data_i == ex_rs2_data_i);
            BR_BNE:  cond_taken_s = (ex_rs1_data_i != ex_rs2_data_i);
            BR_BLT:  cond_taken_s = ($signed(ex_rs1_data_i) <  $signed(ex_rs2_data_i));
            BR_BGE:  cond_taken_s = ($signed(ex_rs1_data_i) >= $signed(ex_rs2_data_i));
            BR_BLTU: cond_taken_s = (ex_rs1_data_i <  ex_rs2_data_i);
            BR_BGEU: cond_taken_s = (ex_rs1_data_i >= ex_rs2_data_i);
            default: cond_taken_s = 1'b0;
        endcase
    end

    // Actual outcome, target and mispredict; JALR takes priority over JAL.
    always_comb begin
        is_jump_s = ex_is_jal_i | ex_is_jalr_i;
        if (ex_is_jalr_i) begin
            act_target_s = (ex_rs1_data_i + ex_imm_i) & JALR_MASK;
        end else begin
            act_target_s = ex_pc_i + ex_imm_i;
        end
        act_taken_s = is_jump_s | cond_taken_s;
        if (act_taken_s) begin
            act_next_pc_s = act_target_s;
        end else begin
            act_next_pc_s = ex_pc_i + PC_STEP;
        end
        mispredict_s = (act_taken_s != ex_pred_taken_i) ||
                       (act_taken_s && (act_target_s != ex_pred_target_i));
        // Instructions arriving while a redirect is out are on the wrong path.
        accept_s = ex_valid_i && !redirect_valid_r;
    end

    // Saturating counter step for the resolving branch.
    always_comb begin
        bht_next_s = bht_r[ex_bht_idx_s];
        if (cond_taken_s) begin
            if (bht_r[ex_bht_idx_s] != 2'b11) begin
                bht_next_s = bht_r[ex_bht_idx_s] + 2'b01;
            end else begin
                bht_next_s = 2'b11;
            end
        end else begin
            if (bht_r[ex_bht_idx_s] != 2'b00) begin
                bht_next_s = bht_r[ex_bht_idx_s] - 2'b01;
            end else begin
                bht_next_s = 2'b00;
            end
        end
    end

    // BHT and BTB valid bits: reset to weakly-not-taken / empty, trained on accept.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
            btb_valid_r <= '0;
        end else if (accept_s) begin
            if (!is_jump_s) begin
                bht_r[ex_bht_idx_s] <= bht_next_s;
            end
            if (act_taken_s) begin
                btb_valid_r[ex_btb_idx_s] <= 1'b1;
            end
        end
    end

    // BTB payload needs no reset; the valid bit guards it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept_s && act_taken_s) begin
            btb_tag_r[ex_btb_idx_s]    <= ex_tag_s;
            btb_target_r[ex_btb_idx_s] <= act_target_s;
            btb_jump_r[ex_btb_idx_s]   <= is_jump_s;
        end
    end

    // Registered redirect and trace outcome.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
            resolved_taken_r <= 1'b0;
        end else begin
            redirect_valid_r <= accept_s && mispredict_s;
            if (accept_s) begin
                resolved_taken_r <= act_taken_s;
                if (mispredict_s) begin
                    redirect_pc_r <= act_next_pc_s;
                end
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            branch_cnt_r     <= '0;
            mispredict_cnt_r <= '0;
        end else if (accept_s) begin
            branch_cnt_r <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (mispredict_s) begin
                mispredict_cnt_r <= mispredict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_r;
    assign mispredict_cnt_o = mispredict_cnt_r;
`else
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

    assign pred_taken_o     = pred_taken_s;
    assign pred_target_o    = pred_target_s;
    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign resolved_taken_o = resolved_taken_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: resolve vector table with a
// scoreboard of expected registered results, plus hand-written multi-cycle sequences.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_ptarget;
    logic [2:0]  ex_bt;
    logic        ex_jal, ex_jalr, ex_ptaken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resolved_taken;
    logic [31:0] branch_cnt, mispredict_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int exp_br  = 0;
    int exp_mp  = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .if_valid_i       (if_valid),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_rs1_data_i    (ex_rs1),
        .ex_rs2_data_i    (ex_rs2),
        .ex_imm_i         (ex_imm),
        .ex_branch_type_i (ex_bt),
        .ex_is_jal_i      (ex_jal),
        .ex_is_jalr_i     (ex_jalr),
        .ex_pred_taken_i  (ex_ptaken),
        .ex_pred_target_i (ex_ptarget),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .resolved_taken_o (resolved_taken),
        .branch_cnt_o     (branch_cnt),
        .mispredict_cnt_o (mispredict_cnt)
    );

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [2:0]  bt;
        logic        jal, jalr, ptaken;
        logic [31:0] ptarget;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    typedef struct {
        logic        redir;
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef BP_PERF_CNT_EN
        chk({name, "_branch_cnt"}, branch_cnt, exp_br);
        chk({name, "_mispredict_cnt"}, mispredict_cnt, exp_mp);
`else
        chk({name, "_branch_cnt"}, branch_cnt, 32'd0);
        chk({name, "_mispredict_cnt"}, mispredict_cnt, 32'd0);
`endif
    endtask

    task automatic set_ex(input vec_t v);
        ex_pc = v.pc; ex_rs1 = v.rs1; ex_rs2 = v.rs2; ex_imm = v.imm;
        ex_bt = v.bt; ex_jal = v.jal; ex_jalr = v.jalr;
        ex_ptaken = v.ptaken; ex_ptarget = v.ptarget;
    endtask

    task automatic push_exp(input vec_t v);
        sb_q.push_back('{v.exp_redir, v.exp_pc, v.exp_taken});
        exp_br++;
        if (v.exp_redir) exp_mp++;
    endtask

    task automatic check_sb(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.redir});
            chk({name, "_resolved_taken"}, {31'd0, resolved_taken}, {31'd0, e.taken});
            if (e.redir) chk({name, "_redirect_pc"}, redirect_pc, e.pc);
        end
    endtask

    // One resolve: drive at a falling edge, check the registered result one cycle later.
    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        set_ex(v);
        ex_valid = 1'b1;
        push_exp(v);
        @(negedge clk);
        ex_valid = 1'b0;
        check_sb(name);
    endtask

    task automatic resolve(input string name, input logic [31:0] pc, rs1, rs2, imm,
                           input logic [2:0] bt, input logic jal, jalr, pt,
                           input logic [31:0] ptg, input logic er, input logic [31:0] epc,
                           input logic et);
        vec_t v;
        v = '{pc, rs1, rs2, imm, bt, jal, jalr, pt, ptg, er, epc, et};
        run_vec(name, v);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc, input logic v,
                          input logic et, input logic [31:0] etg);
        @(negedge clk);
        if_valid = v;
        if_pc = pc;
        #1;
        chk({name, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, et});
        chk({name, "_pred_target"}, pred_target, etg);
        if_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_br = 0;
        exp_mp = 0;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            pc            rs1           rs2           imm           bt      jal   jalr  pt    ptarget       redir pc            taken
        vecs[0]  = '{32'h0000_0200, 32'd5,        32'd5,        32'h40,       3'b000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0240, 1'b1};
        vecs[1]  = '{32'h0000_0300, 32'hFFFF_FFFF, 32'd1,       32'h20,       3'b100, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0320, 1'b1};
        vecs[2]  = '{32'h0000_0400, 32'hFFFF_FFFF, 32'd1,       32'h20,       3'b110, 1'b0, 1'b0, 1'b1, 32'h420,      1'b1, 32'h0000_0404, 1'b0};
        vecs[3]  = '{32'h0000_0500, 32'h1003,     32'd0,        32'h0,        3'b000, 1'b0, 1'b1, 1'b1, 32'h1002,     1'b0, 32'h0,         1'b1};
        vecs[4]  = '{32'h0000_0500, 32'h1003,     32'd0,        32'h0,        3'b000, 1'b0, 1'b1, 1'b1, 32'h1000,     1'b1, 32'h0000_1002, 1'b1};
        vecs[5]  = '{32'h0000_0600, 32'd3,        32'd3,        32'h40,       3'b001, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0};
        vecs[6]  = '{32'h0000_0604, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFF0, 3'b101, 1'b0, 1'b0, 1'b1, 32'h5F4,    1'b0, 32'h0,         1'b1};
        vecs[7]  = '{32'h0000_0608, 32'd1,        32'hFFFF_FFFF, 32'h40,      3'b111, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0};
        vecs[8]  = '{32'h0000_0700, 32'd0,        32'd0,        32'h100,      3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0800, 1'b1};
        vecs[9]  = '{32'h0000_0704, 32'h2000,     32'd0,        32'h10,       3'b000, 1'b1, 1'b1, 1'b1, 32'h714,      1'b1, 32'h0000_2010, 1'b1};
        vecs[10] = '{32'h0000_0708, 32'd7,        32'd7,        32'h40,       3'b010, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0};
        vecs[11] = '{32'hFFFF_FFF0, 32'd0,        32'd0,        32'h20,       3'b000, 1'b1, 1'b0, 1'b1, 32'h10,       1'b0, 32'h0,         1'b1};
        vecs[12] = '{32'h0000_0900, 32'd0,        32'd0,        32'h8,        3'b000, 1'b0, 1'b0, 1'b1, 32'h904,      1'b1, 32'h0000_0908, 1'b1};

        rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'h0; ex_valid = 1'b0;
        ex_pc = 32'h0; ex_rs1 = 32'h0; ex_rs2 = 32'h0; ex_imm = 32'h0; ex_bt = 3'b000;
        ex_jal = 1'b0; ex_jalr = 1'b0; ex_ptaken = 1'b0; ex_ptarget = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and a cold lookup
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_resolved_taken", {31'd0, resolved_taken}, 32'd0);
        chk_cnt("rst");
        lookup("cold", 32'h100, 1'b1, 1'b0, 32'h104);

        // Table of resolves
        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end
        chk_cnt("table");

        // Training: first taken BEQ at 0x200, then predicted taken via BTB
        do_reset();
        resolve("beq_train", 32'h200, 32'd5, 32'd5, 32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,
                1'b1, 32'h240, 1'b1);
        chk_cnt("beq_train");
        lookup("after_train", 32'h200, 1'b1, 1'b1, 32'h240);
        lookup("if_invalid", 32'h200, 1'b0, 1'b0, 32'h204);

        // Saturation: two more taken (01->10->11->11), then two not-taken back to 01
        resolve("sat_t1", 32'h200, 32'd5, 32'd5, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 32'h240,
                1'b0, 32'h0, 1'b1);
        resolve("sat_t2", 32'h200, 32'd5, 32'd5, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 32'h240,
                1'b0, 32'h0, 1'b1);
        resolve("sat_nt1", 32'h200, 32'd5, 32'd6, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 32'h240,
                1'b1, 32'h204, 1'b0);
        lookup("sat_mid", 32'h200, 1'b1, 1'b1, 32'h240);
        // Second not-taken with a same-index lookup in the same cycle
        v = '{32'h200, 32'd5, 32'd6, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 32'h240, 1'b1, 32'h204, 1'b0};
        @(negedge clk);
        set_ex(v);
        ex_valid = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h200;
        push_exp(v);
        #1;
        chk("collide_old_taken", {31'd0, pred_taken}, 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        check_sb("sat_nt2");
        #1;
        chk("collide_new_taken", {31'd0, pred_taken}, 32'd0);
        chk("collide_new_target", pred_target, 32'h204);
        if_valid = 1'b0;

        // Shadow: a resolve in the redirect cycle is ignored
        do_reset();
        v = '{32'h200, 32'd5, 32'd5, 32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h240, 1'b1};
        @(negedge clk);
        set_ex(v);
        ex_valid = 1'b1;
        push_exp(v);
        @(negedge clk);
        check_sb("shadow_first");
        chk_cnt("shadow_first");
        ex_imm = 32'h80;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("shadow_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk_cnt("shadow_after");
        resolve("shadow_nt", 32'h200, 32'd5, 32'd6, 32'h40, 3'b000, 1'b0, 1'b0, 1'b1, 32'h240,
                1'b1, 32'h204, 1'b0);
        lookup("shadow_bht", 32'h200, 1'b1, 1'b0, 32'h204);
        chk_cnt("shadow_end");

        // Reset asserted during the redirect cycle
        @(negedge clk);
        ex_pc = 32'h700; ex_imm = 32'h100; ex_jal = 1'b1; ex_jalr = 1'b0;
        ex_ptaken = 1'b0; ex_ptarget = 32'h0;
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        ex_jal = 1'b0;
        chk("rstmid_redirect_before", {31'd0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_br = 0;
        exp_mp = 0;
        chk("rstmid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rstmid_redirect_pc", redirect_pc, 32'd0);
        chk("rstmid_resolved_taken", {31'd0, resolved_taken}, 32'd0);
        chk_cnt("rstmid");
        lookup("rstmid_btb_empty", 32'h700, 1'b1, 1'b0, 32'h704);
        lookup("rstmid_bht_reset", 32'h200, 1'b1, 1'b0, 32'h204);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch decision logic; owns prediction and resolution for all control-flow instructions.
- Fetch side: same-cycle prediction from a BHT of 2-bit saturating counters plus a direct-mapped tagged BTB.
- Execute side: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, trains both tables and issues a registered redirect on misprediction.
- Sits between IF (PC select) and EX.

Parameters:
- XLEN, 32, data/address width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, ≥2.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- if_valid_i  in  1  fetch lookup request.
- if_pc_i  in  XLEN  fetch PC.
- pred_taken_o  out  1  predicted taken; combinational from if_pc_i.
- pred_target_o  out  XLEN  predicted next PC.
- ex_valid_i  in  1  control-flow instruction resolving in EX.
- ex_pc_i  in  XLEN  PC of the resolving instruction.
- ex_rs1_data_i  in  XLEN  rs1 operand.
- ex_rs2_data_i  in  XLEN  rs2 operand.
- ex_imm_i  in  XLEN  sign-extended immediate.
- ex_branch_type_i  in  3  butterfly_pkg BR_* encoding (funct3 values).
- ex_is_jal_i  in  1  JAL.
- ex_is_jalr_i  in  1  JALR.
- ex_pred_taken_i  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target_i  in  XLEN  predicted next PC carried down the pipe.
- redirect_valid_o  out  1  mispredict flush/redirect, registered.
- redirect_pc_o  out  XLEN  correct next PC, registered.
- resolved_taken_o  out  1  registered actual outcome, for trace.
- branch_cnt_o  out  CNT_W  resolved control-flow count.
- mispredict_cnt_o  out  CNT_W  mispredict count.

Behaviour:
- Indexing:
  - BHT index = pc[log2(BHT_ENTRIES)+1:2].
  - BTB index = pc[log2(BTB_ENTRIES)+1:2].
  - BTB tag = pc[XLEN-1:log2(BTB_ENTRIES)+2].
  - Each BTB entry holds {valid, tag, target, is_jump}.
- Prediction (combinational, tables read before write):
  - hit = valid && tag match.
  - taken = hit && (is_jump || bht[idx][1]).
  - pred_target_o = taken ? btb.target : if_pc_i+4.
  - Both outputs are 0 / if_pc_i+4 when if_valid_i=0.
- Resolution, on ex_valid_i:
  - Conditional branch: taken per BR_* comparison; signed for BLT/BGE, unsigned for BLTU/BGEU; any other encoding resolves not-taken.
  - JAL: always taken; target = ex_pc_i+ex_imm_i.
  - JALR: always taken; target = (ex_rs1_data_i+ex_imm_i) & ~1.
  - If JAL and JALR are both high, JALR wins.
  - All additions wrap modulo 2^XLEN.
  - Actual next PC = taken ? target : ex_pc_i+4.
- Mispredict = (taken != ex_pred_taken_i) || (taken && target != ex_pred_target_i).
- Training, at the clock edge ending the resolve cycle:
  - Conditional branch: BHT counter +1 if taken, −1 if not; saturates at 3 and 0.
  - Taken branch or jump: write BTB entry {1, tag, target, is_jump}, overwriting any alias.
  - Not-taken branches leave the BTB untouched.
- Outputs and latency:
  - redirect_valid_o rises exactly 1 cycle after a mispredicting resolve and is high for one cycle per event; redirect_pc_o = actual next PC.
  - resolved_taken_o updates on every accepted resolve and holds otherwise.
- Shadow rule: ex_valid_i in a cycle where redirect_valid_o=1 is a wrong-path instruction. It is ignored: no training, no counting, no redirect.
- Same-cycle collision: a lookup and an update to the same index see the old table contents; the new value is visible next cycle.
- Reset (rst_ni=0 at clock edge), including mid-operation:
  - All BHT counters become 2'b01 (weakly not-taken).
  - All BTB valid bits clear; BTB target/tag need no reset.
  - redirect_valid_o=0, redirect_pc_o=0, resolved_taken_o=0, counters=0.
  - A pending redirect is dropped.
- Performance counters:
  - branch_cnt_o increments per accepted resolve.
  - mispredict_cnt_o increments per mispredict.
  - Both wrap at 2^CNT_W.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined: branch_cnt_o and mispredict_cnt_o are implemented as above.
- Undefined: no counter flops are built and both ports are tied to 0.
- Prediction, training and redirect behaviour are identical in both builds.

Test Plan:
- Reset, then lookup if_pc_i=0x100 → pred_taken_o=0, pred_target_o=0x104; all outputs 0.
- BEQ at 0x200, rs1=rs2=5, imm=0x40, ex_pred_taken_i=0 → next cycle redirect_valid_o=1 and redirect_pc_o=0x240 for one cycle. A following lookup at 0x200 → pred_taken_o=1 (counter 10), pred_target_o=0x240.
- BLT with rs1=0xFFFFFFFF, rs2=1 resolves taken; BLTU with the same operands resolves not-taken. Each compared against the opposite prediction → redirect to target and to pc+4 respectively.
- Repeated taken resolves at one PC saturate the counter at 3; two not-taken resolves then bring it to 1 → prediction not-taken.
- JALR with rs1=0x1003, imm=0 and correct prediction 0x1002 → no redirect; the same JALR predicted to 0x1000 → redirect_pc_o=0x1002.
- Mispredict followed by ex_valid_i in the redirect cycle → second instruction not counted, no BHT change. Also: assert rst_ni=0 during the redirect cycle → redirect cleared next cycle and BTB empty. With BP_PERF_CNT_EN, counters read 1/1 after the first mispredict.
